// File: rtl/cordic_pkg.sv
// cordic_pkg
//   Shared definitions for the circular CORDIC blocks (rotation and vectoring).
//   Angles are degrees scaled by 2^8 (Q8.8). The arctan table is shared so both
//   CORDIC flavours agree bit-for-bit on the angle format.
// Contents
//   ANGLE_90 / ANGLE_180  quadrant constants in degrees*2^8
//   CORDIC_GAIN_Q8        uncompensated CORDIC gain K~1.6468 scaled by 2^8
//   GUARD                 extra fractional bits carried in the x/y datapath
//   cordic_state_e        sequencer states
//   cordic_atan(i)        atan(2^-i) in degrees*2^8
package cordic_pkg;

  localparam int ANGLE_90       = 23040;
  localparam int ANGLE_180      = 46080;
  localparam int CORDIC_GAIN_Q8 = 422;

  // Fractional bits kept below the integer x/y values. Without them the
  // arithmetic right shift of a small negative y sticks at -1 and both the
  // magnitude and the angle drift in the late iterations.
  localparam int GUARD = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ROT  = 2'd1,
    ST_DONE = 2'd2
  } cordic_state_e;

  function automatic logic [15:0] cordic_atan(input logic [3:0] i);
    logic [15:0] a;
    case (i)
      4'd0:    a = 16'd11520;
      4'd1:    a = 16'd6800;
      4'd2:    a = 16'd3593;
      4'd3:    a = 16'd1824;
      4'd4:    a = 16'd915;
      4'd5:    a = 16'd458;
      4'd6:    a = 16'd229;
      4'd7:    a = 16'd114;
      4'd8:    a = 16'd57;
      4'd9:    a = 16'd28;
      4'd10:   a = 16'd14;
      4'd11:   a = 16'd7;
      4'd12:   a = 16'd3;
      4'd13:   a = 16'd1;
      default: a = 16'd0;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/cordic_vec_stage.sv
// cordic_vec_stage
//   One combinational vectoring-mode micro-rotation. The direction is chosen
//   to drive y toward zero; y == 0 counts as positive.
// Ports
//   x_i, y_i  current vector (signed, XW bits)
//   z_i       accumulated angle (signed, ZW bits)
//   i_i       iteration index, also the shift amount
//   alpha_i   atan(2^-i) for this iteration
//   x_o, y_o  rotated vector
//   z_o       updated angle
module cordic_vec_stage
  import cordic_pkg::*;
#(
  parameter int XW = 26,
  parameter int ZW = 19
) (
  input  logic signed [XW-1:0] x_i,
  input  logic signed [XW-1:0] y_i,
  input  logic signed [ZW-1:0] z_i,
  input  logic        [3:0]    i_i,
  input  logic signed [ZW-1:0] alpha_i,
  output logic signed [XW-1:0] x_o,
  output logic signed [XW-1:0] y_o,
  output logic signed [ZW-1:0] z_o
);

  logic signed [XW-1:0] xShift;
  logic signed [XW-1:0] yShift;

  // Both shifted terms come from the old x/y so the pair updates together.
  always_comb begin
    xShift = x_i >>> i_i;
    yShift = y_i >>> i_i;
    if (!y_i[XW-1]) begin
      x_o = x_i + yShift;
      y_o = y_i - xShift;
      z_o = z_i + alpha_i;
    end else begin
      x_o = x_i - yShift;
      y_o = y_i + xShift;
      z_o = z_i - alpha_i;
    end
  end

endmodule

// File: rtl/cordic_vectoring.sv
// cordic_vectoring
//   Iterative circular CORDIC in vectoring mode. Rotates (X,Y) onto the
//   positive x axis over ITER micro-rotations and reports the angle
//   atan2(Y,X) in degrees*2^8 and the gain-scaled magnitude K*|(X,Y)|.
// Ports
//   clk         rising-edge clock
//   sync_reset  synchronous active-high reset; wins over start
//   start       request, accepted in IDLE or DONE, ignored while busy
//   X, Y        signed input vector
//   busy        high while rotating
//   done        one-cycle pulse, results valid from this cycle
//   theta_out   signed angle, range (-46080, +46080]
//   mag_out     unsigned magnitude, not gain-compensated
module cordic_vectoring
  import cordic_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int ITER  = 16
) (
  input  logic                    clk,
  input  logic                    sync_reset,
  input  logic                    start,
  input  logic signed [WIDTH-1:0] X,
  input  logic signed [WIDTH-1:0] Y,
  output logic                    busy,
  output logic                    done,
  output logic signed [WIDTH:0]   theta_out,
  output logic        [WIDTH+1:0] mag_out
);

  localparam int XW = WIDTH + 2 + GUARD;
  localparam int ZW = WIDTH + 3;
  localparam int TW = WIDTH + 1;
  localparam int MW = WIDTH + 2;

  localparam logic signed [ZW-1:0] Z_90      = ZW'(ANGLE_90);
  localparam logic signed [ZW-1:0] Z_180     = ZW'(ANGLE_180);
  localparam logic signed [ZW-1:0] Z_MIN     = ZW'(1 - ANGLE_180);
  localparam logic signed [XW-1:0] MAG_ROUND = XW'(2 ** (GUARD - 1));
  localparam logic        [3:0]    LAST_I    = 4'(ITER - 1);

  cordic_state_e state_q, state_d;

  logic signed [XW-1:0] x_q, x_d;
  logic signed [XW-1:0] y_q, y_d;
  logic signed [ZW-1:0] z_q, z_d;
  logic        [3:0]    i_q, i_d;
  logic                 forceTheta_q, forceTheta_d;
  logic                 thetaPi_q, thetaPi_d;
  logic                 zeroMag_q, zeroMag_d;
  logic signed [TW-1:0] theta_q, theta_d;
  logic        [MW-1:0] mag_q, mag_d;

  logic signed [XW-1:0] xExt;
  logic signed [XW-1:0] yExt;
  logic signed [ZW-1:0] alpha;
  logic signed [XW-1:0] stageX;
  logic signed [XW-1:0] stageY;
  logic signed [ZW-1:0] stageZ;

  // Inputs widened and moved up into the guard-bit fixed-point format.
  assign xExt  = XW'(X) <<< GUARD;
  assign yExt  = XW'(Y) <<< GUARD;
  assign alpha = ZW'(cordic_atan(i_q));

  cordic_vec_stage #(
    .XW(XW),
    .ZW(ZW)
  ) u_stage (
    .x_i    (x_q),
    .y_i    (y_q),
    .z_i    (z_q),
    .i_i    (i_q),
    .alpha_i(alpha),
    .x_o    (stageX),
    .y_o    (stageY),
    .z_o    (stageZ)
  );

  // State and datapath registers; reset clears everything including outputs.
  always_ff @(posedge clk) begin
    if (sync_reset) begin
      state_q      <= ST_IDLE;
      x_q          <= '0;
      y_q          <= '0;
      z_q          <= '0;
      i_q          <= '0;
      forceTheta_q <= 1'b0;
      thetaPi_q    <= 1'b0;
      zeroMag_q    <= 1'b0;
      theta_q      <= '0;
      mag_q        <= '0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      z_q          <= z_d;
      i_q          <= i_d;
      forceTheta_q <= forceTheta_d;
      thetaPi_q    <= thetaPi_d;
      zeroMag_q    <= zeroMag_d;
      theta_q      <= theta_d;
      mag_q        <= mag_d;
    end
  end

  // Sequencer: load with quadrant pre-rotation, iterate, publish on the last
  // micro-rotation. Left-half-plane vectors are pre-rotated by +/-90 degrees
  // so the micro-rotations only need to cover +/-99.9 degrees.
  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    z_d          = z_q;
    i_d          = i_q;
    forceTheta_d = forceTheta_q;
    thetaPi_d    = thetaPi_q;
    zeroMag_d    = zeroMag_q;
    theta_d      = theta_q;
    mag_d        = mag_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d      = ST_ROT;
          i_d          = '0;
          // On the x axis the angle is exact (0 or +180); the origin also
          // reports zero magnitude instead of the accumulated table sum.
          forceTheta_d = (Y == '0);
          thetaPi_d    = X[WIDTH-1];
          zeroMag_d    = (X == '0) && (Y == '0);
          if (!X[WIDTH-1]) begin
            x_d = xExt;
            y_d = yExt;
            z_d = '0;
          end else if (!Y[WIDTH-1]) begin
            x_d = yExt;
            y_d = -xExt;
            z_d = Z_90;
          end else begin
            x_d = -yExt;
            y_d = xExt;
            z_d = -Z_90;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_ROT: begin
        x_d = stageX;
        y_d = stageY;
        z_d = stageZ;
        i_d = i_q + 4'd1;
        if (i_q == LAST_I) begin
          state_d = ST_DONE;
          if (zeroMag_q) begin
            mag_d = '0;
          end else begin
            mag_d = MW'((stageX + MAG_ROUND) >>> GUARD);
          end
          // Table truncation can push angles near +/-180 slightly past the
          // boundary; keep the result inside (-180, +180].
          if (forceTheta_q) begin
            theta_d = thetaPi_q ? TW'(Z_180) : '0;
          end else if (stageZ > Z_180) begin
            theta_d = TW'(Z_180);
          end else if (stageZ < Z_MIN) begin
            theta_d = TW'(Z_MIN);
          end else begin
            theta_d = TW'(stageZ);
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign busy      = (state_q == ST_ROT);
  assign done      = (state_q == ST_DONE);
  assign theta_out = theta_q;
  assign mag_out   = mag_q;

endmodule
